// File: rtl/sd_norm_int_ctrl.sv
// Normal Interrupt Status producer/clear logic: sticky event capture,
// W1C host access over a req/ack handshake, and interrupt generation.
module sd_norm_int_ctrl #(
  parameter int WIDTH       = 16,
  parameter int STICKY_BITS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STICKY_BITS-1:0] evt_in,
  input  logic                   card_int_in,
  input  logic                   err_sum_in,
  input  logic [WIDTH-1:0]       stat_en,
  input  logic [WIDTH-1:0]       sig_en,
  input  logic                   wr_req,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_req,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   ack,
  output logic                   irq_out,
  output logic [WIDTH-1:0]       status_out
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    HOLD
  } state_e;

  state_e                 state_q, state_d;
  logic                   is_wr_q, is_wr_d;
  logic [STICKY_BITS-1:0] sticky_q, sticky_d;
  logic [STICKY_BITS-1:0] clr;
  logic [WIDTH-1:0]       rd_data_q, rd_data_d;
  logic                   ack_q, ack_d;
  logic                   irq_q, irq_d;
  logic [WIDTH-1:0]       status;

  // Bits above the sticky field are live levels, never cleared by W1C.
  always_comb begin
    status                   = '0;
    status[STICKY_BITS-1:0]  = sticky_q;
    status[STICKY_BITS]      = stat_en[STICKY_BITS] & card_int_in;
    status[WIDTH-1]          = stat_en[WIDTH-1] & err_sum_in;
  end

  always_comb begin
    state_d   = state_q;
    is_wr_d   = is_wr_q;
    ack_d     = 1'b0;
    rd_data_d = rd_data_q;
    clr       = '0;
    unique case (state_q)
      IDLE: begin
        if (wr_req) begin
          state_d = XFER;
          is_wr_d = 1'b1;
          ack_d   = 1'b1;
        end else if (rd_req) begin
          state_d = XFER;
          is_wr_d = 1'b0;
          ack_d   = 1'b1;
        end
      end
      XFER: begin
        state_d = HOLD;
        if (is_wr_q) clr = wr_data[STICKY_BITS-1:0];
        else         rd_data_d = status;
      end
      HOLD: begin
        if (!wr_req && !rd_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Set wins over a same-cycle clear; disabling a bit drops it.
    sticky_d = stat_en[STICKY_BITS-1:0]
             & ((sticky_q & ~clr) | evt_in);
    irq_d    = |(status & sig_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      is_wr_q   <= 1'b0;
      sticky_q  <= '0;
      rd_data_q <= '0;
      ack_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_wr_q   <= is_wr_d;
      sticky_q  <= sticky_d;
      rd_data_q <= rd_data_d;
      ack_q     <= ack_d;
      irq_q     <= irq_d;
    end
  end

  assign rd_data    = rd_data_q;
  assign ack        = ack_q;
  assign irq_out    = irq_q;
  assign status_out = status;

endmodule

// File: tb/tb_sd_norm_int_ctrl.sv
// Bench for sd_norm_int_ctrl: directed plan steps plus random traffic,
// all checked each cycle against a behavioural model.
module tb_sd_norm_int_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  evt_in;
  logic        card_int_in;
  logic        err_sum_in;
  logic [15:0] stat_en;
  logic [15:0] sig_en;
  logic        wr_req;
  logic [15:0] wr_data;
  logic        rd_req;
  logic [15:0] rd_data;
  logic        ack;
  logic        irq_out;
  logic [15:0] status_out;

  int total = 0;
  int bad   = 0;

  // model: sticky bits, read buffer, ack, irq and access phase
  logic [7:0]  m_sticky = '0;
  logic [15:0] m_rd     = '0;
  logic        m_ack    = 1'b0;
  logic        m_irq    = 1'b0;
  int          m_phase  = 0;  // 0 waiting, 1 serving, 2 awaiting release
  bit          m_wr     = 1'b0;

  sd_norm_int_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .evt_in      (evt_in),
    .card_int_in (card_int_in),
    .err_sum_in  (err_sum_in),
    .stat_en     (stat_en),
    .sig_en      (sig_en),
    .wr_req      (wr_req),
    .wr_data     (wr_data),
    .rd_req      (rd_req),
    .rd_data     (rd_data),
    .ack         (ack),
    .irq_out     (irq_out),
    .status_out  (status_out)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] m_status();
    return {stat_en[15] & err_sum_in, 6'b0,
            stat_en[8] & card_int_in, m_sticky};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [15:0] st;
    logic [7:0]  clrm, ns;
    logic [15:0] nrd;
    logic        nirq;
    int          np;
    bit          nwr;
    st  = m_status();
    np  = m_phase;
    nwr = m_wr;
    if (rst) begin
      ns = '0; nrd = '0; nirq = 1'b0; np = 0;
    end else begin
      clrm = (m_phase == 1 && m_wr) ? wr_data[7:0] : 8'h00;
      ns   = stat_en[7:0] & ((m_sticky & ~clrm) | evt_in);
      nirq = |(st & sig_en);
      nrd  = (m_phase == 1 && !m_wr) ? st : m_rd;
      if (m_phase == 0) begin
        if (wr_req)      begin np = 1; nwr = 1'b1; end
        else if (rd_req) begin np = 1; nwr = 1'b0; end
      end else if (m_phase == 1) begin
        np = 2;
      end else if (!wr_req && !rd_req) begin
        np = 0;
      end
    end
    @(posedge clk);
    m_sticky = ns;
    m_rd     = nrd;
    m_irq    = nirq;
    m_phase  = np;
    m_wr     = nwr;
    m_ack    = (np == 1);
    #1;
    chk("status", status_out, m_status());
    chk("ack", {15'b0, ack}, {15'b0, m_ack});
    chk("irq", {15'b0, irq_out}, {15'b0, m_irq});
    chk("rd_data", rd_data, m_rd);
  endtask

  initial begin
    rst = 1'b1; evt_in = 8'hFF; card_int_in = 1'b0; err_sum_in = 1'b0;
    stat_en = 16'hFFFF; sig_en = 16'h0000;
    wr_req = 1'b0; wr_data = 16'h0000; rd_req = 1'b0;

    // reset
    tick(); tick();
    chk("rst_status", status_out, 16'h0000);
    chk("rst_irq", {15'b0, irq_out}, 16'h0000);
    chk("rst_ack", {15'b0, ack}, 16'h0000);
    rst = 1'b0;
    tick();
    chk("post_rst_set", status_out, 16'h00FF);
    evt_in = 8'h00;
    wr_req = 1'b1; wr_data = 16'hFFFF;
    tick(); tick();
    wr_req = 1'b0;
    tick();
    chk("clr_all", status_out, 16'h0000);

    // sticky + W1C
    sig_en = 16'h0001;
    evt_in = 8'h01; tick(); evt_in = 8'h00;
    chk("sticky", status_out, 16'h0001);
    tick();
    chk("irq_set", {15'b0, irq_out}, 16'h0001);
    wr_req = 1'b1; wr_data = 16'h0001;
    tick();
    chk("w1c_ack", {15'b0, ack}, 16'h0001);
    tick();
    chk("w1c_ack_once", {15'b0, ack}, 16'h0000);
    chk("w1c_clear", status_out, 16'h0000);
    wr_req = 1'b0;
    tick();
    chk("irq_clr", {15'b0, irq_out}, 16'h0000);

    // simultaneous set and clear
    evt_in = 8'h02; tick(); evt_in = 8'h00;
    wr_req = 1'b1; wr_data = 16'h0002;
    tick();
    evt_in = 8'h02; tick(); evt_in = 8'h00;
    chk("set_wins", status_out, 16'h0002);
    wr_req = 1'b0; tick();
    wr_req = 1'b1; tick(); tick();
    chk("clr_bit1", status_out, 16'h0000);
    wr_req = 1'b0; tick();

    // masking
    stat_en = 16'hFFF7;
    evt_in = 8'h08; tick(); evt_in = 8'h00;
    chk("mask_bit3", status_out, 16'h0000);
    stat_en = 16'hFFFF;
    evt_in = 8'h04; tick(); evt_in = 8'h00;
    chk("set_bit2", status_out, 16'h0004);
    stat_en = 16'hFFFB; tick();
    chk("disable_bit2", status_out, 16'h0000);
    stat_en = 16'hFFFF; sig_en = 16'h0000;
    evt_in = 8'h04; tick(); evt_in = 8'h00;
    tick(); tick();
    chk("irq_masked", {15'b0, irq_out}, 16'h0000);
    stat_en = 16'hFFFB; tick(); stat_en = 16'hFFFF;

    // read-only bits
    card_int_in = 1'b1; err_sum_in = 1'b1;
    #1;
    chk("ro_bits", status_out, 16'h8100);
    wr_req = 1'b1; wr_data = 16'hFFFF;
    tick(); tick();
    wr_req = 1'b0; tick();
    chk("ro_w1c", status_out, 16'h8100);
    rd_req = 1'b1; tick();
    chk("rd_ack", {15'b0, ack}, 16'h0001);
    tick();
    chk("rd_data_ro", rd_data, 16'h8100);
    chk("rd_ack_once", {15'b0, ack}, 16'h0000);
    rd_req = 1'b0; tick();
    card_int_in = 1'b0; err_sum_in = 1'b0;

    // handshake: write priority, one ack per access
    wr_req = 1'b1; rd_req = 1'b1; wr_data = 16'h0000;
    tick();
    chk("both_ack", {15'b0, ack}, 16'h0001);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("both_no_reack", {15'b0, ack}, 16'h0000);
    end
    chk("both_write_won", rd_data, 16'h8100);
    wr_req = 1'b0; rd_req = 1'b0; tick();
    rd_req = 1'b1; tick();
    chk("new_rd_ack", {15'b0, ack}, 16'h0001);
    rd_req = 1'b0; tick(); tick();

    // reset during HOLD
    wr_req = 1'b1; tick(); tick();
    rst = 1'b1; tick();
    chk("rst_hold_ack", {15'b0, ack}, 16'h0000);
    rst = 1'b0; wr_req = 1'b0; tick();
    rd_req = 1'b1; tick();
    chk("post_rst_ack", {15'b0, ack}, 16'h0001);
    rd_req = 1'b0; tick(); tick();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rst         = ($urandom_range(0, 99) == 0);
      evt_in      = 8'($urandom) & 8'($urandom) & 8'($urandom);
      card_int_in = ($urandom_range(0, 3) == 0);
      err_sum_in  = ($urandom_range(0, 3) == 0);
      stat_en     = ($urandom_range(0, 7) == 0) ? 16'($urandom)
                                                : 16'hFFFF;
      sig_en      = 16'($urandom);
      wr_req      = ($urandom_range(0, 2) == 0);
      rd_req      = ($urandom_range(0, 2) == 0);
      wr_data     = 16'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
